// File: rtl/counter_display_pkg.sv
// Shared types and helpers for the counter/display slice: 7-segment glyphs,
// the BCD converter state encoding and a constant-width helper.
package counter_display_pkg;

  // Glyphs are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result published
// only in DONE so consumers never see a half-converted value.
module bin2bcd_seq
  import counter_display_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_W-1:0]     bin_in,
  output logic [NDIGITS*4-1:0] bcd_out,
  output logic                 done
);

  localparam int BCD_W = NDIGITS * 4;
  localparam int CW    = clog2(BIN_W + 1);

  bcd_state_t         r_state;
  bcd_state_t         w_nextState;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_scratch;
  logic [BCD_W-1:0]   w_adj;
  logic [CW-1:0]      r_bitCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Leave SHIFT on the cycle that performs the last of BIN_W shifts.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = SHIFT;
      SHIFT:   if (r_bitCnt == CW'(1)) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    done = (r_state == DONE);
  end

  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < NDIGITS; k++) begin
      if (r_scratch[k*4 +: 4] >= 4'd5) w_adj[k*4 +: 4] = r_scratch[k*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_bitCnt  <= '0;
      bcd_out   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_bin     <= bin_in;
          r_scratch <= '0;
          r_bitCnt  <= CW'(BIN_W);
        end
        SHIFT: begin
          r_scratch <= BCD_W'({w_adj, r_bin[BIN_W-1]});
          r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
          r_bitCnt  <= r_bitCnt - CW'(1);
        end
        DONE:    bcd_out <= r_scratch;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/param_counter_display.sv
// Up/down/loadable modulo counter with a multiplexed 7-segment readout,
// all in the clk domain driven by clock-enable ticks.
module param_counter_display
  import counter_display_pkg::*;
#(
  parameter int COUNT_W     = 14,
  parameter int NDIGITS     = 4,
  parameter int MAX_COUNT   = 9999,
  parameter int TICK_DIV    = 100_000_000,
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_LZ    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up_dn,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] count,
  output logic [6:0]         seg,
  output logic [NDIGITS-1:0] an
);

  localparam int BCD_W = NDIGITS * 4;
  localparam int PW    = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
  localparam int RW    = (REFRESH_DIV > 1) ? clog2(REFRESH_DIV) : 1;
  localparam int IW    = (NDIGITS > 1) ? clog2(NDIGITS) : 1;
  localparam logic [PW-1:0]      PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0]      REF_MAX   = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]      IDX_MAX   = IW'(NDIGITS - 1);
  localparam logic [COUNT_W-1:0] MAX_C     = COUNT_W'(MAX_COUNT);

  logic [PW-1:0]      r_presc;
  logic               w_tick;
  logic [RW-1:0]      r_refresh;
  logic [IW-1:0]      r_idx;
  logic [BCD_W-1:0]   w_bcd;
  logic               w_done;
  logic [NDIGITS-1:0] w_lz;
  logic [3:0]         w_nibble;
  logic               w_blank;

  assign w_tick = (r_presc == PRESC_MAX);

  // A load restarts the tick period so the next step is a full period away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_presc <= '0;
    else if (load || w_tick)  r_presc <= '0;
    else                      r_presc <= r_presc + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val > MAX_C) ? MAX_C : load_val;
    end else if (w_tick && en) begin
      if (up_dn) count <= (count == MAX_C) ? '0 : count + COUNT_W'(1);
      else       count <= (count == '0) ? MAX_C : count - COUNT_W'(1);
    end
  end

  bin2bcd_seq #(.BIN_W(COUNT_W), .NDIGITS(NDIGITS)) u_bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (1'b1),
    .bin_in  (count),
    .bcd_out (w_bcd),
    .done    (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else if (r_refresh == REF_MAX) begin
      r_refresh <= '0;
      r_idx     <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  // w_lz[k] is set when digit k and every digit above it are zero.
  always_comb begin
    w_lz = '0;
    w_lz[NDIGITS-1] = (w_bcd[BCD_W-1 -: 4] == 4'd0);
    for (int k = NDIGITS - 2; k >= 0; k--) begin
      w_lz[k] = w_lz[k+1] && (w_bcd[k*4 +: 4] == 4'd0);
    end
  end

  assign w_nibble = w_bcd[r_idx*4 +: 4];
  assign w_blank  = (BLANK_LZ != 0) && (r_idx != '0) && w_lz[r_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= w_blank ? SEG_BLANK : seg_decode(w_nibble);
      an  <= ~(NDIGITS'(1) << r_idx);
    end
  end

endmodule
